// File: rtl/txn_ring_fifo_if.sv
// Bus bundle for txn_ring_fifo: push/pop handshakes, transaction controls,
// and the occupancy/status outputs.
//   master : producer/consumer side (drives requests and transaction controls)
//   slave  : the FIFO itself (drives done pulses, read data, counts and flags)
// Parameters must match those given to the txn_ring_fifo instance.
interface txn_ring_fifo_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
);
    logic              push_req;
    logic [DATA_W-1:0] push_data;
    logic              push_done;
    logic              w_open;
    logic              w_commit;
    logic              w_rollback;
    logic              pop_req;
    logic [DATA_W-1:0] pop_data;
    logic              pop_done;
    logic              r_open;
    logic              r_commit;
    logic              r_rollback;
    logic [CNT_W-1:0]  used;
    logic [CNT_W-1:0]  level;
    logic [CNT_W-1:0]  free;
    logic              full;
    logic              empty;
    logic              overflow;

    modport master (
        output push_req, push_data, w_open, w_commit, w_rollback,
        output pop_req, r_open, r_commit, r_rollback,
        input  push_done, pop_data, pop_done,
        input  used, level, free, full, empty, overflow
    );

    modport slave (
        input  push_req, push_data, w_open, w_commit, w_rollback,
        input  pop_req, r_open, r_commit, r_rollback,
        output push_done, pop_data, pop_done,
        output used, level, free, full, empty, overflow
    );
endinterface

// File: rtl/txn_ring_fifo.sv
// Transactional ring buffer with internal storage.
// Writes can be grouped in a transaction and committed or rolled back as a
// unit; reads can be grouped so popped words can be re-read until released.
// All DEPTH cells are usable because occupancy is kept in explicit counters.
// Ports:
//   clk   - clock
//   nRst  - asynchronous active-low reset
//   bus   - txn_ring_fifo_if.slave (push/pop handshakes, txn controls, status)
//
// The ring is split into three contiguous segments:
//   rrel..rptr  popped inside a read txn, not yet released  (rpend)
//   rptr..wcmt  committed and readable                       (used)
//   wcmt..wptr  pushed inside a write txn, not yet committed (wpend)
// level = rpend + used + wpend.
module txn_ring_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nRst,
    txn_ring_fifo_if.slave   bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wptr_q, wptr_d, wcmt_q, wcmt_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d, rrel_q, rrel_d;
    logic              wt_q, wt_d, rt_q, rt_d;
    logic [CNT_W-1:0]  used_q, used_d, level_q, level_d;
    logic [CNT_W-1:0]  wpend_q, wpend_d, rpend_q, rpend_d;
    logic              push_done_q, pop_done_q, overflow_q;
    logic [DATA_W-1:0] pop_data_q;

    logic              full_w;
    logic              push_acc, pop_acc;
    logic              w_rb, w_cm, w_hold;
    logic              r_rb, r_cm, r_hold;
    logic [CNT_W-1:0]  used_add, used_back;

    // Wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_w   = (level_q == CNT_DEPTH);
    assign push_acc = bus.push_req && !full_w && !bus.w_rollback;
    assign pop_acc  = bus.pop_req && (used_q != '0) && !bus.r_rollback;

    // Commit/rollback only act on an open transaction; rollback wins.
    assign w_rb   = bus.w_rollback && wt_q;
    assign w_cm   = bus.w_commit && wt_q && !bus.w_rollback;
    assign w_hold = wt_q || bus.w_open;
    assign r_rb   = bus.r_rollback && rt_q;
    assign r_cm   = bus.r_commit && rt_q && !bus.r_rollback;
    assign r_hold = rt_q || bus.r_open;

    always_comb begin
        wptr_d    = wptr_q;
        wcmt_d    = wcmt_q;
        wpend_d   = wpend_q;
        wt_d      = wt_q;
        rptr_d    = rptr_q;
        rrel_d    = rrel_q;
        rpend_d   = rpend_q;
        rt_d      = rt_q;
        used_add  = '0;
        used_back = '0;

        if (w_rb || w_cm) begin
            wt_d = 1'b0;
        end else if (bus.w_open) begin
            wt_d = 1'b1;
        end

        if (push_acc) begin
            wptr_d = ptr_inc(wptr_q);
        end

        if (w_rb) begin
            wptr_d  = wcmt_q;
            wpend_d = '0;
        end else if (w_cm) begin
            // Commit includes a push made in the same cycle.
            wcmt_d   = wptr_d;
            wpend_d  = '0;
            used_add = wpend_q + CNT_W'(push_acc);
        end else if (push_acc) begin
            if (w_hold) begin
                wpend_d = wpend_q + CNT_W'(1);
            end else begin
                wcmt_d   = wptr_d;
                used_add = CNT_W'(1);
            end
        end

        if (r_rb || r_cm) begin
            rt_d = 1'b0;
        end else if (bus.r_open) begin
            rt_d = 1'b1;
        end

        if (pop_acc) begin
            rptr_d = ptr_inc(rptr_q);
        end

        if (r_rb) begin
            rptr_d    = rrel_q;
            rpend_d   = '0;
            used_back = rpend_q;
        end else if (r_cm) begin
            rrel_d  = rptr_d;
            rpend_d = '0;
        end else if (pop_acc) begin
            if (r_hold) begin
                rpend_d = rpend_q + CNT_W'(1);
            end else begin
                rrel_d = rptr_d;
            end
        end

        used_d  = used_q + used_add + used_back - CNT_W'(pop_acc);
        level_d = rpend_d + used_d + wpend_d;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wptr_q      <= '0;
            wcmt_q      <= '0;
            rptr_q      <= '0;
            rrel_q      <= '0;
            wt_q        <= 1'b0;
            rt_q        <= 1'b0;
            used_q      <= '0;
            level_q     <= '0;
            wpend_q     <= '0;
            rpend_q     <= '0;
            push_done_q <= 1'b0;
            pop_done_q  <= 1'b0;
            overflow_q  <= 1'b0;
            pop_data_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            wcmt_q      <= wcmt_d;
            rptr_q      <= rptr_d;
            rrel_q      <= rrel_d;
            wt_q        <= wt_d;
            rt_q        <= rt_d;
            used_q      <= used_d;
            level_q     <= level_d;
            wpend_q     <= wpend_d;
            rpend_q     <= rpend_d;
            push_done_q <= push_acc;
            pop_done_q  <= pop_acc;
            overflow_q  <= bus.push_req && full_w;
            if (pop_acc) begin
                pop_data_q <= mem_q[rptr_q];
            end
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wptr_q] <= bus.push_data;
        end
    end

    assign bus.push_done = push_done_q;
    assign bus.pop_done  = pop_done_q;
    assign bus.pop_data  = pop_data_q;
    assign bus.overflow  = overflow_q;
    assign bus.used      = used_q;
    assign bus.level     = level_q;
    assign bus.free      = CNT_DEPTH - level_q;
    assign bus.full      = full_w;
    assign bus.empty     = (used_q == '0);

endmodule

// File: tb/tb_txn_ring_fifo.sv
module tb_txn_ring_fifo;

    logic clk;
    logic nRst;
    int   checks;
    int   errors;

    txn_ring_fifo_if #(.DATA_W(16), .DEPTH(4)) a4 ();
    txn_ring_fifo_if #(.DATA_W(16), .DEPTH(5)) a5 ();

    txn_ring_fifo #(.DATA_W(16), .DEPTH(4)) u_dut4 (.clk(clk), .nRst(nRst), .bus(a4.slave));
    txn_ring_fifo #(.DATA_W(16), .DEPTH(5)) u_dut5 (.clk(clk), .nRst(nRst), .bus(a5.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a4.push_req = 0; a4.push_data = '0; a4.w_open = 0; a4.w_commit = 0; a4.w_rollback = 0;
        a4.pop_req = 0; a4.r_open = 0; a4.r_commit = 0; a4.r_rollback = 0;
        a5.push_req = 0; a5.push_data = '0; a5.w_open = 0; a5.w_commit = 0; a5.w_rollback = 0;
        a5.pop_req = 0; a5.r_open = 0; a5.r_commit = 0; a5.r_rollback = 0;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        idle_all();
        tick(); tick();
        checks++; if (a4.used !== 3'd0) begin errors++; $display("FAIL reset_used got %0d exp 0", a4.used); end
        checks++; if (a4.level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", a4.level); end
        checks++; if (a4.free !== 3'd4) begin errors++; $display("FAIL reset_free got %0d exp 4", a4.free); end
        checks++; if (a5.free !== 3'd5) begin errors++; $display("FAIL reset_free5 got %0d exp 5", a5.free); end
        checks++; if ({a4.empty, a4.full, a4.push_done, a4.pop_done, a4.overflow} !== 5'b10000) begin
            errors++; $display("FAIL reset_flags got %b exp 10000", {a4.empty, a4.full, a4.push_done, a4.pop_done, a4.overflow}); end
        checks++; if (a4.pop_data !== 16'h0) begin errors++; $display("FAIL reset_pop_data got %h exp 0000", a4.pop_data); end
        nRst = 1'b1;
        tick();
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 4; i++) begin
            a4.push_req = 1; a4.push_data = 16'((i + 1) * 16'h11);
            tick();
            checks++; if (a4.push_done !== 1'b1) begin errors++; $display("FAIL fill_push_done[%0d] got %b exp 1", i, a4.push_done); end
        end
        checks++; if (a4.used !== 3'd4 || a4.full !== 1'b1 || a4.free !== 3'd0) begin
            errors++; $display("FAIL fill_full used %0d full %b free %0d exp 4 1 0", a4.used, a4.full, a4.free); end
        a4.push_data = 16'h55;
        tick();
        checks++; if (a4.overflow !== 1'b1 || a4.push_done !== 1'b0) begin
            errors++; $display("FAIL overflow_pulse ovf %b done %b exp 1 0", a4.overflow, a4.push_done); end
        checks++; if (a4.used !== 3'd4) begin errors++; $display("FAIL overflow_used got %0d exp 4", a4.used); end
        a4.push_req = 0;
        tick();
        checks++; if (a4.overflow !== 1'b0) begin errors++; $display("FAIL overflow_one_cycle got %b exp 0", a4.overflow); end
        for (int i = 0; i < 4; i++) begin
            a4.pop_req = 1;
            tick();
            checks++; if (a4.pop_done !== 1'b1 || a4.pop_data !== 16'((i + 1) * 16'h11)) begin
                errors++; $display("FAIL drain_data[%0d] done %b data %h exp 1 %h", i, a4.pop_done, a4.pop_data, 16'((i + 1) * 16'h11)); end
        end
        a4.pop_req = 0;
        checks++; if (a4.level !== 3'd0 || a4.empty !== 1'b1) begin
            errors++; $display("FAIL drain_empty level %0d empty %b exp 0 1", a4.level, a4.empty); end
    endtask

    task automatic test_write_txn();
        a4.w_open = 1; tick(); a4.w_open = 0;
        a4.push_req = 1; a4.push_data = 16'hA1; tick();
        a4.push_data = 16'hA2; tick();
        a4.push_req = 0;
        checks++; if (a4.level !== 3'd2 || a4.used !== 3'd0) begin
            errors++; $display("FAIL wtxn_pending level %0d used %0d exp 2 0", a4.level, a4.used); end
        a4.w_rollback = 1; tick(); a4.w_rollback = 0;
        checks++; if (a4.level !== 3'd0 || a4.used !== 3'd0) begin
            errors++; $display("FAIL wtxn_rollback level %0d used %0d exp 0 0", a4.level, a4.used); end
        a4.w_open = 1; tick(); a4.w_open = 0;
        a4.push_req = 1; a4.push_data = 16'hA1; tick();
        a4.push_data = 16'hA2; tick();
        a4.push_data = 16'hA3; a4.w_commit = 1; tick();
        a4.push_req = 0; a4.w_commit = 0;
        checks++; if (a4.used !== 3'd3 || a4.level !== 3'd3 || a4.push_done !== 1'b1) begin
            errors++; $display("FAIL wtxn_commit used %0d level %0d done %b exp 3 3 1", a4.used, a4.level, a4.push_done); end
        a4.pop_req = 1; tick();
        checks++; if (a4.pop_data !== 16'hA1) begin errors++; $display("FAIL wtxn_pop0 got %h exp a1", a4.pop_data); end
        tick();
        checks++; if (a4.pop_data !== 16'hA2) begin errors++; $display("FAIL wtxn_pop1 got %h exp a2", a4.pop_data); end
        tick();
        checks++; if (a4.pop_data !== 16'hA3) begin errors++; $display("FAIL wtxn_pop2 got %h exp a3", a4.pop_data); end
        a4.pop_req = 0;
    endtask

    task automatic test_read_txn();
        a4.push_req = 1; a4.push_data = 16'hB1; tick();
        a4.push_data = 16'hB2; tick();
        a4.push_req = 0;
        checks++; if (a4.used !== 3'd2) begin errors++; $display("FAIL rtxn_setup used %0d exp 2", a4.used); end
        a4.r_open = 1; tick(); a4.r_open = 0;
        a4.pop_req = 1; tick();
        checks++; if (a4.pop_data !== 16'hB1) begin errors++; $display("FAIL rtxn_pop0 got %h exp b1", a4.pop_data); end
        tick();
        checks++; if (a4.pop_data !== 16'hB2) begin errors++; $display("FAIL rtxn_pop1 got %h exp b2", a4.pop_data); end
        checks++; if (a4.used !== 3'd0 || a4.level !== 3'd2 || a4.free !== 3'd2 || a4.empty !== 1'b1) begin
            errors++; $display("FAIL rtxn_held used %0d level %0d free %0d empty %b exp 0 2 2 1", a4.used, a4.level, a4.free, a4.empty); end
        tick();
        checks++; if (a4.pop_done !== 1'b0 || a4.pop_data !== 16'hB2) begin
            errors++; $display("FAIL rtxn_pop_empty done %b data %h exp 0 b2", a4.pop_done, a4.pop_data); end
        a4.pop_req = 0; a4.r_rollback = 1; tick(); a4.r_rollback = 0;
        checks++; if (a4.used !== 3'd2 || a4.level !== 3'd2) begin
            errors++; $display("FAIL rtxn_rollback used %0d level %0d exp 2 2", a4.used, a4.level); end
        a4.pop_req = 1; tick();
        checks++; if (a4.pop_data !== 16'hB1 || a4.level !== 3'd1) begin
            errors++; $display("FAIL rtxn_reread data %h level %0d exp b1 1", a4.pop_data, a4.level); end
        a4.r_commit = 1; tick();
        a4.pop_req = 0; a4.r_commit = 0;
        checks++; if (a4.pop_data !== 16'hB2 || a4.level !== 3'd0 || a4.empty !== 1'b1) begin
            errors++; $display("FAIL rtxn_release data %h level %0d empty %b exp b2 0 1", a4.pop_data, a4.level, a4.empty); end
    endtask

    task automatic test_back_to_back();
        a4.push_req = 1; a4.push_data = 16'hC1; tick();
        a4.push_data = 16'hC2; a4.pop_req = 1; tick();
        a4.push_req = 0;
        checks++; if (a4.pop_data !== 16'hC1 || a4.pop_done !== 1'b1 || a4.push_done !== 1'b1 || a4.used !== 3'd1) begin
            errors++; $display("FAIL b2b_pushpop data %h pdone %b wdone %b used %0d exp c1 1 1 1", a4.pop_data, a4.pop_done, a4.push_done, a4.used); end
        tick();
        a4.pop_req = 0;
        checks++; if (a4.pop_data !== 16'hC2 || a4.used !== 3'd0) begin
            errors++; $display("FAIL b2b_second data %h used %0d exp c2 0", a4.pop_data, a4.used); end
        a4.w_open = 1; tick(); a4.w_open = 0;
        a4.push_req = 1; a4.push_data = 16'hD1; a4.w_rollback = 1; tick();
        a4.push_req = 0; a4.w_rollback = 0;
        checks++; if (a4.push_done !== 1'b0 || a4.level !== 3'd0) begin
            errors++; $display("FAIL b2b_push_rollback done %b level %0d exp 0 0", a4.push_done, a4.level); end
        a4.push_req = 1; a4.push_data = 16'hE1; tick(); a4.push_req = 0;
        checks++; if (a4.used !== 3'd1) begin errors++; $display("FAIL b2b_after_rb used %0d exp 1", a4.used); end
        a4.pop_req = 1; tick(); a4.pop_req = 0;
        checks++; if (a4.pop_data !== 16'hE1) begin errors++; $display("FAIL b2b_after_rb_data got %h exp e1", a4.pop_data); end
    endtask

    task automatic test_wrap();
        int  pushed;
        int  exp_rd;
        int  cnt;
        int  c;
        bit  push_ok;
        bit  pop_ok;
        pushed = 0; exp_rd = 1; cnt = 0; c = 0;
        while ((pushed < 13 || cnt > 0) && c < 80) begin
            a5.push_req  = (pushed < 13);
            a5.push_data = 16'(pushed + 1);
            a5.pop_req   = (pushed >= 13) || (c % 3 == 2);
            push_ok = a5.push_req && (cnt < 5);
            pop_ok  = a5.pop_req && (cnt > 0);
            tick();
            cnt = cnt + int'(push_ok) - int'(pop_ok);
            checks++; if (a5.push_done !== push_ok || a5.overflow !== (a5.push_req && !push_ok) || a5.pop_done !== pop_ok) begin
                errors++; $display("FAIL wrap_pulses c%0d wd %b ov %b pd %b exp %b %b %b", c, a5.push_done, a5.overflow, a5.pop_done,
                                   push_ok, a5.push_req && !push_ok, pop_ok); end
            if (pop_ok) begin
                checks++; if (a5.pop_data !== 16'(exp_rd)) begin
                    errors++; $display("FAIL wrap_data c%0d got %h exp %h", c, a5.pop_data, 16'(exp_rd)); end
                exp_rd++;
            end
            checks++; if (a5.used !== 3'(cnt) || a5.level !== 3'(cnt) || a5.free !== 3'(5 - cnt) ||
                          a5.full !== (cnt == 5) || a5.empty !== (cnt == 0)) begin
                errors++; $display("FAIL wrap_counts c%0d used %0d level %0d free %0d full %b empty %b exp cnt %0d", c,
                                   a5.used, a5.level, a5.free, a5.full, a5.empty, cnt); end
            if (push_ok) pushed++;
            c++;
        end
        a5.push_req = 0; a5.pop_req = 0;
        checks++; if (exp_rd != 14) begin errors++; $display("FAIL wrap_total popped %0d exp 13 (cycles %0d)", exp_rd - 1, c); end
    endtask

    task automatic test_async_reset();
        a4.w_open = 1; tick(); a4.w_open = 0;
        a4.push_req = 1;
        for (int i = 0; i < 3; i++) begin
            a4.push_data = 16'(16'hF0 + i);
            tick();
        end
        a4.push_req = 0;
        checks++; if (a4.level !== 3'd3 || a4.used !== 3'd0) begin
            errors++; $display("FAIL areset_setup level %0d used %0d exp 3 0", a4.level, a4.used); end
        #2 nRst = 1'b0;
        #1;
        checks++; if (a4.used !== 3'd0 || a4.level !== 3'd0 || a4.free !== 3'd4 || a4.empty !== 1'b1 || a4.full !== 1'b0) begin
            errors++; $display("FAIL areset_counts used %0d level %0d free %0d empty %b full %b exp 0 0 4 1 0",
                               a4.used, a4.level, a4.free, a4.empty, a4.full); end
        checks++; if (a4.push_done !== 1'b0 || a4.pop_data !== 16'h0) begin
            errors++; $display("FAIL areset_outputs done %b data %h exp 0 0000", a4.push_done, a4.pop_data); end
        tick();
        nRst = 1'b1;
        tick();
        a4.push_req = 1; a4.push_data = 16'h1F; tick(); a4.push_req = 0;
        checks++; if (a4.push_done !== 1'b1 || a4.used !== 3'd1) begin
            errors++; $display("FAIL areset_push done %b used %0d exp 1 1", a4.push_done, a4.used); end
        a4.pop_req = 1; tick(); a4.pop_req = 0;
        checks++; if (a4.pop_done !== 1'b1 || a4.pop_data !== 16'h1F || a4.level !== 3'd0) begin
            errors++; $display("FAIL areset_pop done %b data %h level %0d exp 1 1f 0", a4.pop_done, a4.pop_data, a4.level); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill_overflow();
        test_write_txn();
        test_read_txn();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/txn_ring_fifo.md
Name: txn_ring_fifo

Overview:
Parametrised transactional ring buffer with internal storage. It supports both write-side transactions (open/commit/rollback of pushed words) and read-side transactions (popped words can be re-read until released). It sits between the SPI and MIL-1553 packet engines, so a whole packet can be discarded on a framing error and retransmitted on a bus NAK. Unlike the previous generation, all DEPTH cells are usable, the read side is transactional, and overflow is reported.

Parameters:
DATA_W, 16, data word width
DEPTH, 8, number of storage words; any value >= 2 (power of two not required)
CNT_W, $clog2(DEPTH+1), width of the count outputs (derived; do not override)

Ports:
clk  in  1  clock
nRst  in  1  asynchronous active-low reset
push_req  in  1  write request, sampled each clk
push_data  in  DATA_W  write data
push_done  out  1  registered pulse: the push of the previous cycle was stored
w_open  in  1  start write transaction
w_commit  in  1  make pending writes readable
w_rollback  in  1  discard pending writes
pop_req  in  1  read request
pop_data  out  DATA_W  read data, valid while pop_done=1
pop_done  out  1  registered pulse: pop_data holds the word popped in the previous cycle
r_open  in  1  start read transaction
r_commit  in  1  release words popped inside the transaction
r_rollback  in  1  rewind the read pointer to the last released word
used  out  CNT_W  committed words not yet popped (readable)
level  out  CNT_W  occupied cells, including pending writes and unreleased reads
free  out  CNT_W  DEPTH - level
full  out  1  level == DEPTH
empty  out  1  used == 0
overflow  out  1  registered pulse: a push was rejected because the buffer was full

Behaviour:
- Reset (async, nRst=0): all pointers, counts, transaction flags and outputs go to 0 immediately. used=level=0, free=DEPTH, empty=1. Memory contents are not cleared.
- Pointers: wptr (write head), wcmt (committed tail), rptr (read head), rrel (released tail).
  - Each pointer increments modulo DEPTH by comparing against DEPTH-1, not by bit truncation.
  - Counts are kept explicitly, so all DEPTH cells are usable; no spare cell is reserved.
- Push: accepted when push_req=1, free>0, and w_rollback=0 in that cycle.
  - On accept: mem[wptr]<=push_data and wptr advances.
  - push_done=1 in the next cycle. Latency is 1 clk.
  - If free==0: nothing is written, no push_done, overflow=1 for one cycle.
- Pop: accepted when pop_req=1, used>0, and r_rollback=0 in that cycle.
  - On accept: pop_data<=mem[rptr] is registered, rptr advances, pop_done=1 in the next cycle.
  - If used==0: the request is ignored, with no pop_done and no error flag.
  - pop_data holds its last value otherwise.
- Write transaction:
  - Flag wt sets on w_open and clears on w_commit or w_rollback.
  - With wt=0 (and no w_open in the same cycle), an accepted push also advances wcmt, so the word is readable the next cycle.
  - With wt=1 or w_open=1, pushes stay pending: level grows, used does not.
  - w_commit: wcmt <= wptr after this cycle's push, so a same-cycle push is included.
  - w_rollback: wptr <= wcmt, and a same-cycle push is discarded.
- Read transaction:
  - Flag rt sets on r_open and clears on r_commit or r_rollback.
  - With rt=0 (and no r_open in the same cycle), an accepted pop also advances rrel, freeing the cell.
  - With rt=1, popped cells stay occupied: level is unchanged, used decreases.
  - r_commit: rrel <= rptr after this cycle's pop, so a same-cycle pop is included.
  - r_rollback: rptr <= rrel, a same-cycle pop is ignored, and used recovers.
- Priority: rollback beats commit when both are asserted in one cycle. Open while already open has no effect. Commit or rollback without an open transaction has no effect.
- Arithmetic:
  - level = words from rrel to wptr.
  - used = words from rptr to wcmt.
  - Simultaneous accepted push and pop in one cycle: both take effect. The pop sees only data committed before this cycle.
  - Counts update by +1, -1 or by reload from the pointer distance. They never exceed DEPTH and never go below 0.
- Outputs full, empty, used, level and free are derived from registered state and valid in the cycle after the causing event.

Test Plan:
- DEPTH=4, reset, 4 pushes 0x11..0x44 with no transaction -> push_done each cycle after a push, used=4, full=1; 5th push -> overflow=1 for one cycle, no push_done, mem unchanged.
- w_open, push 0xA1,0xA2 -> level=2, used=0; w_rollback -> level=0; repeat, then w_commit asserted with push 0xA3 in the same cycle -> used=3; pops return 0xA1,0xA2,0xA3.
- Committed 0xB1,0xB2; r_open, pop 2 -> pop_data 0xB1,0xB2, used=0, level=2, free=DEPTH-2; r_rollback, pop -> 0xB1; pop 0xB2, r_commit -> level=0, empty=1.
- DEPTH=5: stream 13 words 0x01..0x0D with interleaved single pops -> FIFO order preserved across pointer wrap, and used/level/free consistent every cycle.
- used=1: push+pop in the same cycle -> pop returns the old word, used stays 1. Push with w_rollback in the same cycle while wt=1 -> word discarded, no push_done.
- Mid write transaction with level=3, drop nRst with no clock edge -> all outputs 0, free=DEPTH, empty=1 immediately; after release, a push/pop round trip works.
